// File: rtl/alu_sequencer_if.sv
// Command, response and ALU-operand bundle between the sequencer, its
// command source/response sink, and the attached 16-bit combinational ALU.
interface alu_sequencer_if #(
    parameter int N    = 16,
    parameter int NREG = 8
);
    localparam int RW = $clog2(NREG);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [RW-1:0] cmd_rd;
    logic [RW-1:0] cmd_rs1;
    logic [RW-1:0] cmd_rs2;
    logic [N-1:0]  cmd_imm;

    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [2:0]    alu_op;
    logic [N-1:0]  alu_result;
    logic          alu_carry;
    logic          alu_zero;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_data;
    logic          rsp_carry;
    logic          rsp_zero;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  alu_result, alu_carry, alu_zero, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op,
        output rsp_valid, rsp_data, rsp_carry, rsp_zero
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output alu_result, alu_carry, alu_zero, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_data, rsp_carry, rsp_zero
    );
endinterface

// File: rtl/alu_sequencer.sv
// Register-file front end for a combinational ALU: accept a command, present
// latched operands for one EXEC cycle, write back, then hold the response.
module alu_sequencer #(
    parameter int N    = 16,
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus
);
    localparam int RW = $clog2(NREG);

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_LOADI = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [N-1:0] data;
        logic         carry;
        logic         zero;
    } rsp_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [RW-1:0] rd_q, rd_d;
    logic [N-1:0]  imm_q, imm_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  regs_q [NREG];
    logic [N-1:0]  regs_d [NREG];
    rsp_t          rsp_q, rsp_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        a_d     = a_q;
        b_d     = b_q;
        regs_d  = regs_q;
        rsp_d   = rsp_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    rd_d    = bus.cmd_rd;
                    imm_d   = bus.cmd_imm;
                    a_d     = regs_q[bus.cmd_rs1];
                    b_d     = regs_q[bus.cmd_rs2];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Writeback lands here so the next IDLE read sees it (no hazards).
                if (op_q == OP_LOADI) begin
                    regs_d[rd_q] = imm_q;
                    rsp_d = '{data: imm_q, carry: 1'b0, zero: (imm_q == '0)};
                end else begin
                    regs_d[rd_q] = bus.alu_result;
                    rsp_d = '{data: bus.alu_result, carry: bus.alu_carry,
                              zero: bus.alu_zero};
                end
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            regs_q  <= '{default: '0};
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            a_q     <= a_d;
            b_q     <= b_d;
            regs_q  <= regs_d;
            rsp_q   <= rsp_d;
        end
    end

    // Operands come straight from the latches, so they only move on accept/reset.
    assign bus.cmd_ready = (state_q == IDLE) && !rst;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_op    = (op_q == OP_LOADI) ? OP_ADD : op_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_q.data;
    assign bus.rsp_carry = rsp_q.carry;
    assign bus.rsp_zero  = rsp_q.zero;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and randomized checks of alu_sequencer against a register-file
// model; the bench also plays the role of the combinational ALU.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [15:0] mregs [8];

    alu_sequencer_if #(.N(16), .NREG(8)) bus ();
    alu_sequencer #(.N(16), .NREG(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [16:0] alu_ref(input logic [2:0] op,
                                            input logic [15:0] a, b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {a < b, a - b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {a[15], (b >= 16) ? 16'h0 : (a << b[3:0])};
            3'd6:    return {a[0], (b >= 16) ? 16'h0 : (a >> b[3:0])};
            default: return 17'h0;
        endcase
    endfunction

    logic [16:0] alu_out;
    assign alu_out        = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus.alu_result = alu_out[15:0];
    assign bus.alu_carry  = alu_out[16];
    assign bus.alu_zero   = (alu_out[15:0] == 16'h0);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full command: accept, EXEC-cycle operand check, response check
    // (with 'hold' cycles of backpressure), handshake, model update.
    task automatic do_cmd(input logic [2:0] op, input logic [2:0] rd, rs1, rs2,
                          input logic [15:0] imm, input int hold, input string tag,
                          output logic [15:0] d, output logic c, output logic z);
        logic [16:0] e;
        logic [15:0] ea, eb;
        int w;
        ea = mregs[rs1];
        eb = mregs[rs2];
        e  = (op == 3'd7) ? {1'b0, imm} : alu_ref(op, ea, eb);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_rd = rd;
        bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_imm = imm;
        bus.rsp_ready = 1'b0;
        w = 0;
        while (!bus.cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "/accept_in_time"}, 32'(w < 20), 1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_imm = 16'hDEAD;
        chk({tag, "/exec_valid"}, bus.rsp_valid, 0);
        chk({tag, "/exec_ready"}, bus.cmd_ready, 0);
        chk({tag, "/alu_a"}, bus.alu_a, ea);
        chk({tag, "/alu_b"}, bus.alu_b, eb);
        chk({tag, "/alu_op"}, bus.alu_op, (op == 3'd7) ? 3'd0 : op);
        @(negedge clk);
        chk({tag, "/rsp_valid"}, bus.rsp_valid, 1);
        chk({tag, "/rsp_data"}, bus.rsp_data, e[15:0]);
        chk({tag, "/rsp_carry"}, bus.rsp_carry, e[16]);
        chk({tag, "/rsp_zero"}, bus.rsp_zero, 32'(e[15:0] == 16'h0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "/hold_valid"}, bus.rsp_valid, 1);
            chk({tag, "/hold_data"}, bus.rsp_data, e[15:0]);
        end
        d = bus.rsp_data; c = bus.rsp_carry; z = bus.rsp_zero;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, "/idle_valid"}, bus.rsp_valid, 0);
        chk({tag, "/idle_ready"}, bus.cmd_ready, 1);
        mregs[rd] = e[15:0];
    endtask

    initial begin
        logic [15:0] d;
        logic c, z;
        logic [2:0] rop, rrd, rs1, rs2;
        logic [15:0] rimm;
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_rd = 3'd0;
        bus.cmd_rs1 = 3'd0; bus.cmd_rs2 = 3'd0; bus.cmd_imm = 16'h0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst/cmd_ready", bus.cmd_ready, 0);
        chk("rst/rsp_valid", bus.rsp_valid, 0);
        chk("rst/alu_a", bus.alu_a, 0);
        chk("rst/alu_b", bus.alu_b, 0);
        chk("rst/alu_op", bus.alu_op, 0);
        chk("rst/rsp_data", {bus.rsp_data, bus.rsp_carry, bus.rsp_zero}, 0);
        rst = 1'b0;
        #1 chk("rst/ready_after", bus.cmd_ready, 1);

        // LOADI
        do_cmd(3'd7, 3'd1, 3'd0, 3'd0, 16'h00FF, 0, "loadi_ff", d, c, z);
        chk("loadi_ff/data", {d, c, z}, {16'h00FF, 1'b0, 1'b0});
        do_cmd(3'd7, 3'd2, 3'd0, 3'd0, 16'h0000, 0, "loadi_0", d, c, z);
        chk("loadi_0/zero", {d, c, z}, {16'h0000, 1'b0, 1'b1});

        // ADD with carry out, then read r3 back
        do_cmd(3'd7, 3'd1, 3'd0, 3'd0, 16'hFFFF, 0, "ld_r1", d, c, z);
        do_cmd(3'd7, 3'd2, 3'd0, 3'd0, 16'h0001, 0, "ld_r2", d, c, z);
        do_cmd(3'd0, 3'd3, 3'd1, 3'd2, 16'h0, 0, "add_carry", d, c, z);
        chk("add_carry/result", {d, c, z}, {16'h0000, 1'b1, 1'b1});
        do_cmd(3'd0, 3'd4, 3'd3, 3'd0, 16'h0, 0, "add_r3", d, c, z);
        chk("add_r3/result", {d, c, z}, {16'h0000, 1'b0, 1'b1});

        // SUB self, then dependent SUB with borrow
        do_cmd(3'd7, 3'd1, 3'd0, 3'd0, 16'h0005, 0, "ld_r1b", d, c, z);
        do_cmd(3'd7, 3'd2, 3'd0, 3'd0, 16'h0007, 0, "ld_r2b", d, c, z);
        do_cmd(3'd1, 3'd1, 3'd1, 3'd1, 16'h0, 0, "sub_self", d, c, z);
        chk("sub_self/result", {d, c}, {16'h0000, 1'b0});
        do_cmd(3'd1, 3'd4, 3'd1, 3'd2, 16'h0, 0, "sub_borrow", d, c, z);
        chk("sub_borrow/result", {d, c}, {16'hFFF9, 1'b1});

        // Shifts, including amount >= width
        do_cmd(3'd7, 3'd1, 3'd0, 3'd0, 16'h8001, 0, "ld_r1c", d, c, z);
        do_cmd(3'd7, 3'd2, 3'd0, 3'd0, 16'd4, 0, "ld_r2c", d, c, z);
        do_cmd(3'd5, 3'd3, 3'd1, 3'd2, 16'h0, 0, "shl4", d, c, z);
        chk("shl4/result", {d, c}, {16'h0010, 1'b1});
        do_cmd(3'd6, 3'd3, 3'd1, 3'd2, 16'h0, 0, "shr4", d, c, z);
        chk("shr4/result", {d, c}, {16'h0800, 1'b1});
        do_cmd(3'd7, 3'd2, 3'd0, 3'd0, 16'd20, 0, "ld_r2d", d, c, z);
        do_cmd(3'd5, 3'd3, 3'd1, 3'd2, 16'h0, 0, "shl20", d, c, z);
        chk("shl20/result", {d, z}, {16'h0000, 1'b1});

        // Backpressure with a second command waiting
        do_cmd(3'd7, 3'd1, 3'd0, 3'd0, 16'hAAAA, 0, "ld_r1e", d, c, z);
        do_cmd(3'd7, 3'd2, 3'd0, 3'd0, 16'h5555, 0, "ld_r2e", d, c, z);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd4; bus.cmd_rd = 3'd7;
        bus.cmd_rs1 = 3'd1; bus.cmd_rs2 = 3'd2; bus.rsp_ready = 1'b0;
        chk("bp/ready_idle", bus.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_op = 3'd0; bus.cmd_rd = 3'd3; bus.cmd_rs1 = 3'd7; bus.cmd_rs2 = 3'd0;
        chk("bp/exec_ready", bus.cmd_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp/valid", bus.rsp_valid, 1);
            chk("bp/data", bus.rsp_data, 16'hFFFF);
            chk("bp/ready_blocked", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        mregs[7] = 16'hFFFF;
        chk("bp/released_ready", bus.cmd_ready, 1);
        chk("bp/released_valid", bus.rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("bp/second_accepted", bus.cmd_ready, 0);
        chk("bp/second_alu_a", bus.alu_a, 16'hFFFF);
        @(negedge clk);
        chk("bp/second_valid", bus.rsp_valid, 1);
        chk("bp/second_data", bus.rsp_data, 16'hFFFF);
        mregs[3] = 16'hFFFF;
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        // Reset during EXEC abandons the LOADI
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd7; bus.cmd_rd = 3'd5;
        bus.cmd_imm = 16'h1234;
        chk("rstmid/ready", bus.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid/valid", bus.rsp_valid, 0);
        chk("rstmid/ready_in_rst", bus.cmd_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid/no_rsp", bus.rsp_valid, 0);
        end
        do_cmd(3'd3, 3'd6, 3'd5, 3'd0, 16'h0, 0, "rstmid_or", d, c, z);
        chk("rstmid_or/result", {d, z}, {16'h0000, 1'b1});

        // Randomized traffic against the register-file model
        for (int n = 0; n < 40; n++) begin
            rop  = 3'($urandom_range(0, 7));
            rrd  = 3'($urandom_range(0, 7));
            rs1  = 3'($urandom_range(0, 7));
            rs2  = 3'($urandom_range(0, 7));
            rimm = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20))
                                               : 16'($urandom);
            do_cmd(rop, rrd, rs1, rs2, rimm, $urandom_range(0, 3), "rand", d, c, z);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
